// File: rtl/iic_arbiter.sv
// ---------------------------------------------------------------------------
// iic_arbiter
//   Shares one iic_drive instance between two requesters. Each requester's
//   operands are latched into a shadow register on its start pulse. The bus
//   is granted round-robin, and the driver start/ready handshake is
//   sequenced. Read data, completion and error status go back to the owner.
//
// Ports
//   iic_arb_clk / iic_arb_rst : clock, asynchronous active-low reset
//   reqN_start, reqN_rw_flag, reqN_dev_addr, reqN_word_addr, reqN_wdata
//                             : request pulse and operands (N = 0,1)
//   reqN_rdata, reqN_rdata_valid, reqN_done, reqN_ack_error
//                             : per-requester results (pulses except rdata)
//   arb_busy                  : high from grant through the done cycle
//   drv_start, drv_rw_flag, drv_dev_addr, drv_word_addr, drv_wdata
//                             : driver command, operands held grant..done
//   drv_ready, drv_rdata, drv_rdata_valid, drv_ack_error
//                             : driver status
//   dbg_state                 : current FSM state encoding
//
// Handshake: drv_start pulses once per grant. The driver accepts the
// command by dropping drv_ready, and it completes by raising drv_ready
// again. Request starts are single-cycle pulses and have no backpressure.
// A second start before a grant simply overwrites the pending operands.
// ---------------------------------------------------------------------------
module iic_arbiter #(
  parameter logic [27:0] TIMEOUT = 28'd100_000,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              iic_arb_clk,
  input  logic              iic_arb_rst,
  input  logic              req0_start,
  input  logic              req0_rw_flag,
  input  logic [6:0]        req0_dev_addr,
  input  logic [ADDR_W-1:0] req0_word_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rdata_valid,
  output logic              req0_done,
  output logic              req0_ack_error,
  input  logic              req1_start,
  input  logic              req1_rw_flag,
  input  logic [6:0]        req1_dev_addr,
  input  logic [ADDR_W-1:0] req1_word_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rdata_valid,
  output logic              req1_done,
  output logic              req1_ack_error,
  output logic              arb_busy,
  output logic              drv_start,
  output logic              drv_rw_flag,
  output logic [6:0]        drv_dev_addr,
  output logic [ADDR_W-1:0] drv_word_addr,
  output logic [DATA_W-1:0] drv_wdata,
  input  logic              drv_ready,
  input  logic [DATA_W-1:0] drv_rdata,
  input  logic              drv_rdata_valid,
  input  logic              drv_ack_error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_BUSY      = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        pend_q, pend_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [27:0]       cnt_q, cnt_d;

  logic [1:0]        sh_rw_q, sh_rw_d;
  logic [6:0]        sh_dev_q   [2];
  logic [6:0]        sh_dev_d   [2];
  logic [ADDR_W-1:0] sh_word_q  [2];
  logic [ADDR_W-1:0] sh_word_d  [2];
  logic [DATA_W-1:0] sh_wdata_q [2];
  logic [DATA_W-1:0] sh_wdata_d [2];

  logic              drv_rw_q, drv_rw_d;
  logic [6:0]        drv_dev_q, drv_dev_d;
  logic [ADDR_W-1:0] drv_word_q, drv_word_d;
  logic [DATA_W-1:0] drv_wdata_q, drv_wdata_d;

  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic [1:0]        rvalid_q, rvalid_d;

  logic              grant_id;

  always_ff @(posedge iic_arb_clk or negedge iic_arb_rst) begin
    if (!iic_arb_rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 2'b00;
      last_grant_q <= 1'b1;   // req0 wins the first tie
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      sh_rw_q      <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        sh_dev_q[i]   <= '0;
        sh_word_q[i]  <= '0;
        sh_wdata_q[i] <= '0;
        rdata_q[i]    <= '0;
      end
      drv_rw_q     <= 1'b1;
      drv_dev_q    <= '0;
      drv_word_q   <= '0;
      drv_wdata_q  <= '0;
      rvalid_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      sh_rw_q      <= sh_rw_d;
      sh_dev_q     <= sh_dev_d;
      sh_word_q    <= sh_word_d;
      sh_wdata_q   <= sh_wdata_d;
      rdata_q      <= rdata_d;
      drv_rw_q     <= drv_rw_d;
      drv_dev_q    <= drv_dev_d;
      drv_word_q   <= drv_word_d;
      drv_wdata_q  <= drv_wdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    sh_rw_d      = sh_rw_q;
    sh_dev_d     = sh_dev_q;
    sh_word_d    = sh_word_q;
    sh_wdata_d   = sh_wdata_q;
    rdata_d      = rdata_q;
    drv_rw_d     = drv_rw_q;
    drv_dev_d    = drv_dev_q;
    drv_word_d   = drv_word_q;
    drv_wdata_d  = drv_wdata_q;
    rvalid_d     = 2'b00;
    grant_id     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00 && drv_ready) begin
          // On a tie, the requester that was not served last time wins.
          grant_id       = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
          owner_d        = grant_id;
          last_grant_d   = grant_id;
          pend_d[grant_id] = 1'b0;
          drv_rw_d       = sh_rw_q[grant_id];
          drv_dev_d      = sh_dev_q[grant_id];
          drv_word_d     = sh_word_q[grant_id];
          drv_wdata_d    = sh_wdata_q[grant_id];
          busy_d         = 1'b1;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_BUSY: begin
        cnt_d = cnt_q + 28'd1;
        if (drv_ack_error) err_d = 1'b1;
        // Read strobes are only honoured for read transactions.
        if (drv_rdata_valid && drv_rw_q) begin
          rdata_d[owner_q]  = drv_rdata;
          rvalid_d[owner_q] = 1'b1;
        end
        // The incremented count reaches TIMEOUT-1 here, which places the
        // DONE cycle exactly TIMEOUT cycles after drv_start.
        if (cnt_q == TIMEOUT - 28'd2) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (state_q == S_WAIT_BUSY && !drv_ready) begin
          state_d = S_BUSY;
        end else if (state_q == S_BUSY && drv_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Latching follows the grant. A start in the grant cycle therefore
    // re-arms pend, while the grant still takes the previous shadow.
    if (req0_start) begin
      pend_d[0]     = 1'b1;
      sh_rw_d[0]    = req0_rw_flag;
      sh_dev_d[0]   = req0_dev_addr;
      sh_word_d[0]  = req0_word_addr;
      sh_wdata_d[0] = req0_wdata;
    end
    if (req1_start) begin
      pend_d[1]     = 1'b1;
      sh_rw_d[1]    = req1_rw_flag;
      sh_dev_d[1]   = req1_dev_addr;
      sh_word_d[1]  = req1_word_addr;
      sh_wdata_d[1] = req1_wdata;
    end
  end

  assign drv_start        = (state_q == S_ISSUE);
  assign drv_rw_flag      = drv_rw_q;
  assign drv_dev_addr     = drv_dev_q;
  assign drv_word_addr    = drv_word_q;
  assign drv_wdata        = drv_wdata_q;
  assign arb_busy         = busy_q;
  assign req0_done        = (state_q == S_DONE) && !owner_q;
  assign req1_done        = (state_q == S_DONE) && owner_q;
  assign req0_ack_error   = req0_done && err_q;
  assign req1_ack_error   = req1_done && err_q;
  assign req0_rdata       = rdata_q[0];
  assign req1_rdata       = rdata_q[1];
  assign req0_rdata_valid = rvalid_q[0];
  assign req1_rdata_valid = rvalid_q[1];
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iic_arbiter
//   Directed bench for iic_arbiter (TIMEOUT = 50). A behavioural driver
//   answers drv_start. After accepting a command it stays busy 6 cycles and
//   strobes drv_rdata = drv_word_addr ^ 16'h0A50, so address 0 returns
//   16'h0A50. The stimulus pushes the expected grant operands and the
//   completion records into queues. A monitor pops and compares them on
//   each drv_start and each reqN_done.
// ---------------------------------------------------------------------------
module tb_iic_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_start, req0_rw_flag;
  logic [6:0]  req0_dev_addr;
  logic [15:0] req0_word_addr, req0_wdata, req0_rdata;
  logic        req0_rdata_valid, req0_done, req0_ack_error;
  logic        req1_start, req1_rw_flag;
  logic [6:0]  req1_dev_addr;
  logic [15:0] req1_word_addr, req1_wdata, req1_rdata;
  logic        req1_rdata_valid, req1_done, req1_ack_error;
  logic        arb_busy, drv_start, drv_rw_flag;
  logic [6:0]  drv_dev_addr;
  logic [15:0] drv_word_addr, drv_wdata;
  logic        drv_ready, drv_rdata_valid, drv_ack_error;
  logic [15:0] drv_rdata;
  logic [2:0]  dbg_state;

  iic_arbiter #(.TIMEOUT(28'd50), .ADDR_W(16), .DATA_W(16)) dut (
    .iic_arb_clk(clk), .iic_arb_rst(rst_n),
    .req0_start(req0_start), .req0_rw_flag(req0_rw_flag),
    .req0_dev_addr(req0_dev_addr), .req0_word_addr(req0_word_addr),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata),
    .req0_rdata_valid(req0_rdata_valid), .req0_done(req0_done),
    .req0_ack_error(req0_ack_error),
    .req1_start(req1_start), .req1_rw_flag(req1_rw_flag),
    .req1_dev_addr(req1_dev_addr), .req1_word_addr(req1_word_addr),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata),
    .req1_rdata_valid(req1_rdata_valid), .req1_done(req1_done),
    .req1_ack_error(req1_ack_error),
    .arb_busy(arb_busy), .drv_start(drv_start), .drv_rw_flag(drv_rw_flag),
    .drv_dev_addr(drv_dev_addr), .drv_word_addr(drv_word_addr),
    .drv_wdata(drv_wdata), .drv_ready(drv_ready), .drv_rdata(drv_rdata),
    .drv_rdata_valid(drv_rdata_valid), .drv_ack_error(drv_ack_error),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  // completion record: {id, ack_error, rdata_valid_seen, rdata[15:0], latency[7:0]}
  logic [26:0] exp_q[$];
  // grant record: {rw, dev[6:0], word[15:0], wdata[15:0]}
  logic [39:0] exp_grant_q[$];
  logic [15:0] last_rd [2];
  int          drv_mode = 0;   // 0 normal, 1 NACK, 2 ignore drv_start
  int          issue_cnt = 0;
  int          done_total = 0;
  int          done_cnt [2];
  int          issue_cyc_q[$];
  int          done_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected no event", name, act);
  endtask

  // ---------------- driver model ----------------
  initial begin
    int left;
    left = 0;
    drv_ready = 1'b1; drv_rdata = '0; drv_rdata_valid = 1'b0; drv_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      drv_rdata_valid = 1'b0;
      drv_ack_error   = 1'b0;
      if (!rst_n) begin
        drv_ready = 1'b1;
        left = 0;
      end else if (drv_start && drv_mode != 2) begin
        drv_ready = 1'b0;
        left = 6;
      end else if (left > 0) begin
        left--;
        if (left == 4) begin
          drv_rdata_valid = 1'b1;   // strobes on writes too
          drv_rdata       = drv_word_addr ^ 16'h0A50;
          drv_ack_error   = (drv_mode == 1);
        end
        if (left == 0) drv_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [1:0]  rv_seen;
    logic [39:0] cap_ops, cur_ops;
    logic [26:0] act;
    logic [15:0] rd;
    logic        ack;
    int          issue_cyc;
    rv_seen = 2'b00; cap_ops = '0; issue_cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rv_seen = 2'b00;
        continue;
      end
      cur_ops = {drv_rw_flag, drv_dev_addr, drv_word_addr, drv_wdata};
      if (drv_start) begin
        issue_cnt++;
        issue_cyc = cyc;
        issue_cyc_q.push_back(cyc);
        cap_ops = cur_ops;
        check("busy_at_start", arb_busy, 1);
        if (exp_grant_q.size() == 0) fail_evt("unexpected_grant", cur_ops);
        else check("grant_operands", cur_ops, exp_grant_q.pop_front());
      end
      if (req0_rdata_valid) rv_seen[0] = 1'b1;
      if (req1_rdata_valid) rv_seen[1] = 1'b1;
      for (int id = 0; id < 2; id++) begin
        if ((id == 0) ? req0_done : req1_done) begin
          ack = (id == 0) ? req0_ack_error : req1_ack_error;
          rd  = (id == 0) ? req0_rdata : req1_rdata;
          act = {id[0], ack, rv_seen[id], rd, 8'(cyc - issue_cyc)};
          rv_seen[id] = 1'b0;
          done_total++;
          done_cnt[id]++;
          done_cyc_q.push_back(cyc);
          check("ops_stable", cur_ops, cap_ops);
          check("busy_at_done", arb_busy, 1);
          if (exp_q.size() == 0) fail_evt("unexpected_done", act);
          else check("completion", act, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_txn(input bit id, input bit rw, input logic [6:0] dev,
                            input logic [15:0] addr, input logic [15:0] wd,
                            input bit err, input bit rv, input logic [7:0] lat);
    logic [15:0] rd;
    if (rv) begin
      rd = addr ^ 16'h0A50;
      last_rd[id] = rd;
    end else begin
      rd = last_rd[id];
    end
    exp_grant_q.push_back({rw, dev, addr, wd});
    exp_q.push_back({id, err, rv, rd, lat});
  endtask

  task automatic set_req(input bit id, input bit rw, input logic [6:0] dev,
                         input logic [15:0] addr, input logic [15:0] wd);
    if (id == 1'b0) begin
      req0_start = 1'b1; req0_rw_flag = rw; req0_dev_addr = dev;
      req0_word_addr = addr; req0_wdata = wd;
    end else begin
      req1_start = 1'b1; req1_rw_flag = rw; req1_dev_addr = dev;
      req1_word_addr = addr; req1_wdata = wd;
    end
  endtask

  task automatic release_starts();
    @(negedge clk);
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k;
    k = 0;
    while (done_total < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done_total >= target, 1);
  endtask

  task automatic wait_issue(input int target, input int budget);
    int k;
    k = 0;
    while (issue_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("issue_within_budget", issue_cnt >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, start_cyc, icnt;
    rst_n = 1'b0;
    req0_start = 0; req0_rw_flag = 0; req0_dev_addr = '0; req0_word_addr = '0; req0_wdata = '0;
    req1_start = 0; req1_rw_flag = 0; req1_dev_addr = '0; req1_word_addr = '0; req1_wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_arb_busy", arb_busy, 0);
    check("rst_drv_start", drv_start, 0);
    check("rst_drv_rw_flag", drv_rw_flag, 1);
    check("rst_drv_dev_addr", drv_dev_addr, 0);
    check("rst_req0_rdata", req0_rdata, 0);
    check("rst_req1_done", req1_done, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Single read from req0
    issue_cyc_q.delete();
    expect_txn(0, 1, 7'h54, 16'h0000, 16'h0000, 0, 1, 8'd7);
    start_cyc = cyc;
    set_req(0, 1, 7'h54, 16'h0000, 16'h0000);
    release_starts();
    wait_dones(1, 60);
    check("t1_start_to_drv_start", issue_cyc_q[0] - start_cyc, 2);
    check("t1_req0_rdata", req0_rdata, 16'h0A50);
    check("t1_req1_done_cnt", done_cnt[1], 0);
    check("t1_req1_rdata", req1_rdata, 0);

    // 2. Ties after reset: req0 first, then req1; second pair again req0 first
    do_reset();
    issue_cyc_q.delete();
    done_cyc_q.delete();
    base = done_total;
    expect_txn(0, 1, 7'h54, 16'h0010, 16'h0000, 0, 1, 8'd7);
    expect_txn(1, 1, 7'h50, 16'h0020, 16'h0000, 0, 1, 8'd7);
    @(negedge clk);
    set_req(0, 1, 7'h54, 16'h0010, 16'h0000);
    set_req(1, 1, 7'h50, 16'h0020, 16'h0000);
    release_starts();
    wait_dones(base + 2, 80);
    check("t2_idle_gap", issue_cyc_q[1] - done_cyc_q[0], 2);
    expect_txn(0, 1, 7'h54, 16'h0030, 16'h0000, 0, 1, 8'd7);
    expect_txn(1, 1, 7'h50, 16'h0040, 16'h0000, 0, 1, 8'd7);
    set_req(0, 1, 7'h54, 16'h0030, 16'h0000);
    set_req(1, 1, 7'h50, 16'h0040, 16'h0000);
    release_starts();
    wait_dones(base + 4, 80);

    // 3. Fairness: req0 re-requests during its own transaction, req1 pending
    base = done_total;
    icnt = issue_cnt;
    expect_txn(0, 1, 7'h54, 16'h0100, 16'h0000, 0, 1, 8'd7);
    expect_txn(1, 1, 7'h50, 16'h0200, 16'h0000, 0, 1, 8'd7);
    expect_txn(0, 1, 7'h54, 16'h0300, 16'h0000, 0, 1, 8'd7);
    set_req(0, 1, 7'h54, 16'h0100, 16'h0000);
    release_starts();
    wait_issue(icnt + 1, 20);
    set_req(1, 1, 7'h50, 16'h0200, 16'h0000);
    release_starts();
    set_req(0, 1, 7'h54, 16'h0300, 16'h0000);
    release_starts();
    wait_dones(base + 3, 120);
    repeat (10) @(negedge clk);
    check("t3_done_pulses", done_total - base, 3);

    // 4. req1 write answered with NACK
    drv_mode = 1;
    base = done_total;
    expect_txn(1, 0, 7'h50, 16'h0050, 16'h1234, 1, 0, 8'd7);
    set_req(1, 0, 7'h50, 16'h0050, 16'h1234);
    release_starts();
    wait_dones(base + 1, 60);
    drv_mode = 0;

    // 5. Timeout: driver ignores drv_start, keeps drv_ready high
    drv_mode = 2;
    base = done_total;
    expect_txn(0, 1, 7'h54, 16'h0060, 16'h0000, 1, 0, 8'd50);
    set_req(0, 1, 7'h54, 16'h0060, 16'h0000);
    release_starts();
    wait_dones(base + 1, 100);
    @(negedge clk);
    check("t5_back_to_idle", dbg_state, 0);
    drv_mode = 0;
    expect_txn(0, 1, 7'h54, 16'h0070, 16'h0000, 0, 1, 8'd7);
    set_req(0, 1, 7'h54, 16'h0070, 16'h0000);
    release_starts();
    wait_dones(base + 2, 60);

    // 6. Reset while BUSY with req0 pending; no done, pend dropped
    icnt = issue_cnt;
    exp_grant_q.push_back({1'b1, 7'h50, 16'h0080, 16'h0000});
    set_req(1, 1, 7'h50, 16'h0080, 16'h0000);
    release_starts();
    wait_issue(icnt + 1, 20);
    repeat (2) @(negedge clk);
    set_req(0, 1, 7'h54, 16'h00A0, 16'h0000);
    release_starts();
    check("t6_in_busy", dbg_state, 3);
    base = done_total;
    rst_n = 1'b0;
    #1;
    check("t6_arb_busy", arb_busy, 0);
    check("t6_drv_start", drv_start, 0);
    check("t6_drv_rw_flag", drv_rw_flag, 1);
    check("t6_drv_word_addr", drv_word_addr, 0);
    check("t6_req1_rdata", req1_rdata, 0);
    check("t6_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    icnt = issue_cnt;
    repeat (12) @(negedge clk);
    check("t6_no_done", done_total - base, 0);
    check("t6_pend_cleared", issue_cnt - icnt, 0);
    expect_txn(0, 1, 7'h54, 16'h0090, 16'h0000, 0, 1, 8'd7);
    set_req(0, 1, 7'h54, 16'h0090, 16'h0000);
    release_starts();
    wait_dones(base + 1, 60);
    check("t6_req0_rdata", req0_rdata, 16'h0AC0);

    // Final report
    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("grant_q_drained", exp_grant_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

endmodule
